// File: rtl/cpu_hatch_server.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_hatch_server
//  Description : Instruction store behind the CPU hatch fetch port. Serves
//                48-bit words with one-cycle read latency and contains a
//                byte-stream program loader that holds the CPU in reset
//                while a program is being written.
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_hatch_server #(
    parameter int ADDR_WIDTH = 11,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [31:0] hatch_address,
    output logic [47:0] hatch_instruction,
    output logic        cpu_rst_b,
    input  logic        ld_start,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    output logic        ld_busy,
    output logic [15:0] ld_words,
    output logic        ld_overflow
);

    localparam logic [1:0] c_st_run    = 2'd0;
    localparam logic [1:0] c_st_len_hi = 2'd1;
    localparam logic [1:0] c_st_len_lo = 2'd2;
    localparam logic [1:0] c_st_data   = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [47:0] r_mem [DEPTH];
    logic [47:0] r_hatch_instruction;
    logic        r_cpu_rst_b;
    logic [15:0] r_len;
    logic [2:0]  r_byte_cnt;
    logic [39:0] r_shift;
    logic [15:0] r_word_idx;
    logic [15:0] r_ld_words;
    logic        r_ld_overflow;

    logic        w_busy;
    logic        w_accept;
    logic        w_word_done;
    logic        w_in_range;
    logic        w_last_word;
    logic        w_mem_we;
    logic        w_addr_ok;

    assign w_busy      = (r_state != c_st_run);
    assign ld_busy     = w_busy;
    assign ld_ready    = w_busy && !ld_start;
    assign w_accept    = ld_valid && w_busy && !ld_start;
    assign w_word_done = w_accept && (r_state == c_st_data) && (r_byte_cnt == 3'd5);
    // Words beyond the store are still counted but never written.
    assign w_in_range  = (32'(r_word_idx) < 32'(DEPTH));
    // Widened so a full 65535-word length cannot wrap the comparison.
    assign w_last_word = (({1'b0, r_word_idx} + 17'd1) == {1'b0, r_len});
    assign w_mem_we    = w_word_done && w_in_range;
    assign w_addr_ok   = ((hatch_address >> ADDR_WIDTH) == 32'd0);

    assign hatch_instruction = r_hatch_instruction;
    assign cpu_rst_b         = r_cpu_rst_b;
    assign ld_words          = r_ld_words;
    assign ld_overflow       = r_ld_overflow;

    // Loader state register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) r_state <= c_st_run;
        else        r_state <= w_next_state;
    end

    // Next-state logic; a start pulse restarts the load from any state.
    always_comb begin
        w_next_state = r_state;
        if (ld_start) begin
            w_next_state = c_st_len_hi;
        end else begin
            case (r_state)
                c_st_len_hi: if (w_accept) w_next_state = c_st_len_lo;
                c_st_len_lo: if (w_accept)
                    w_next_state = ({r_len[15:8], ld_data} == 16'd0) ? c_st_run : c_st_data;
                c_st_data:   if (w_word_done && w_last_word) w_next_state = c_st_run;
                default:     w_next_state = r_state;
            endcase
        end
    end

    // Fetch response and CPU reset; both registered, so the CPU reset lags the state.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_hatch_instruction <= 48'd0;
            r_cpu_rst_b         <= 1'b0;
        end else begin
            r_cpu_rst_b <= (r_state == c_st_run);
            if ((r_state == c_st_run) && w_addr_ok)
                r_hatch_instruction <= r_mem[hatch_address[ADDR_WIDTH-1:0]];
            else
                r_hatch_instruction <= 48'd0;
        end
    end

    // Loader datapath: length capture, word assembly and load statistics.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_len         <= 16'd0;
            r_byte_cnt    <= 3'd0;
            r_shift       <= 40'd0;
            r_word_idx    <= 16'd0;
            r_ld_words    <= 16'd0;
            r_ld_overflow <= 1'b0;
        end else if (ld_start) begin
            r_byte_cnt    <= 3'd0;
            r_shift       <= 40'd0;
            r_word_idx    <= 16'd0;
            r_ld_words    <= 16'd0;
            r_ld_overflow <= 1'b0;
        end else if (w_accept) begin
            case (r_state)
                c_st_len_hi: r_len[15:8] <= ld_data;
                c_st_len_lo: r_len[7:0]  <= ld_data;
                c_st_data: begin
                    if (r_byte_cnt == 3'd5) begin
                        r_byte_cnt <= 3'd0;
                        r_word_idx <= r_word_idx + 16'd1;
                        if (r_ld_words != 16'hFFFF) r_ld_words <= r_ld_words + 16'd1;
                        if (!w_in_range) r_ld_overflow <= 1'b1;
                    end else begin
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                        r_shift    <= {r_shift[31:0], ld_data};
                    end
                end
                default: r_len <= r_len;
            endcase
        end
    end

    // Instruction store write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[r_word_idx[ADDR_WIDTH-1:0]] <= {r_shift, ld_data};
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_hatch_server.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_hatch_server
//  Description : Self-checking bench for cpu_hatch_server. A full-size store
//                and a 4-word store share the same stimulus so the overflow
//                boundary can be exercised alongside normal loads.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cpu_hatch_server;

    logic        clk = 1'b0;
    logic        rst_b;
    logic [31:0] hatch_address;
    logic        ld_start;
    logic        ld_valid;
    logic [7:0]  ld_data;

    logic [47:0] big_hi,  sml_hi;
    logic        big_crb, sml_crb;
    logic        big_rdy, sml_rdy;
    logic        big_bsy, sml_bsy;
    logic [15:0] big_wds, sml_wds;
    logic        big_ovf, sml_ovf;

    int total = 0;
    int bad   = 0;

    logic [47:0] exp_big_q[$];
    logic [47:0] exp_sml_q[$];

    always #5 clk = ~clk;

    cpu_hatch_server #(.ADDR_WIDTH(11)) dut_big (
        .clk(clk), .rst_b(rst_b), .hatch_address(hatch_address),
        .hatch_instruction(big_hi), .cpu_rst_b(big_crb),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(big_rdy), .ld_busy(big_bsy), .ld_words(big_wds),
        .ld_overflow(big_ovf)
    );

    cpu_hatch_server #(.ADDR_WIDTH(2)) dut_sml (
        .clk(clk), .rst_b(rst_b), .hatch_address(hatch_address),
        .hatch_instruction(sml_hi), .cpu_rst_b(sml_crb),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_ready(sml_rdy), .ld_busy(sml_bsy), .ld_words(sml_wds),
        .ld_overflow(sml_ovf)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    // Present an address, queue the expected words, compare one cycle later.
    task automatic read_check(input logic [31:0] a, input logic [47:0] eb,
                              input logic [47:0] es, input string nm);
        logic [47:0] e;
        @(negedge clk);
        hatch_address = a;
        exp_big_q.push_back(eb);
        exp_sml_q.push_back(es);
        @(posedge clk); #1;
        e = exp_big_q.pop_front();
        total++;
        if (big_hi !== e) begin bad++; $display("FAIL %s big: got %h want %h", nm, big_hi, e); end
        e = exp_sml_q.pop_front();
        total++;
        if (sml_hi !== e) begin bad++; $display("FAIL %s small: got %h want %h", nm, sml_hi, e); end
    endtask

    task automatic pulse_start(input logic v, input logic [7:0] d);
        @(negedge clk);
        ld_start = 1'b1; ld_valid = v; ld_data = d;
        #1;
        total++;
        if (big_rdy !== 1'b0 || sml_rdy !== 1'b0) begin
            bad++; $display("FAIL ready_on_start: got %b/%b want 0/0", big_rdy, sml_rdy);
        end
        @(posedge clk); #1;
        ld_start = 1'b0; ld_valid = 1'b0;
        total++;
        if (big_bsy !== 1'b1 || sml_bsy !== 1'b1) begin
            bad++; $display("FAIL busy_after_start: got %b/%b want 1/1", big_bsy, sml_bsy);
        end
    endtask

    task automatic send_bytes(input logic [7:0] b[$], input bit gap);
        for (int i = 0; i < b.size(); i++) begin
            @(negedge clk);
            ld_valid = 1'b1; ld_data = b[i];
            #1;
            total++;
            if (big_rdy !== 1'b1 || sml_rdy !== 1'b1) begin
                bad++; $display("FAIL ready_byte%0d: got %b/%b want 1/1", i, big_rdy, sml_rdy);
            end
            if (i >= 1) begin
                total++;
                if (big_crb !== 1'b0 || sml_crb !== 1'b0) begin
                    bad++; $display("FAIL cpu_rst_in_load%0d: got %b/%b want 0/0", i, big_crb, sml_crb);
                end
            end
            @(posedge clk); #1;
            ld_valid = 1'b0;
            if (gap && i != b.size() - 1) begin
                @(negedge clk);
                ld_data = 8'h5A;
                #1;
                total++;
                if (big_rdy !== 1'b1 || sml_rdy !== 1'b1) begin
                    bad++; $display("FAIL ready_gap%0d: got %b/%b want 1/1", i, big_rdy, sml_rdy);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    // Busy drops on the last accepted byte; the CPU reset follows one cycle later.
    task automatic check_load_end();
        total++;
        if (big_bsy !== 1'b0 || sml_bsy !== 1'b0 || big_crb !== 1'b0 || sml_crb !== 1'b0) begin
            bad++; $display("FAIL load_end: busy %b/%b cpu_rst_b %b/%b want busy 0 cpu_rst_b 0",
                            big_bsy, sml_bsy, big_crb, sml_crb);
        end
        @(posedge clk); #1;
        total++;
        if (big_crb !== 1'b1 || sml_crb !== 1'b1) begin
            bad++; $display("FAIL cpu_release: got %b/%b want 1/1", big_crb, sml_crb);
        end
    endtask

    task automatic do_load(input logic [47:0] w[$], input bit gap);
        logic [7:0]  q[$];
        logic [15:0] len;
        len = 16'(w.size());
        q.push_back(len[15:8]);
        q.push_back(len[7:0]);
        for (int i = 0; i < w.size(); i++)
            for (int k = 5; k >= 0; k--) q.push_back(w[i][k*8 +: 8]);
        pulse_start(1'b0, 8'h00);
        send_bytes(q, gap);
        check_load_end();
    endtask

    task automatic test_reset();
        rst_b = 1'b0; ld_start = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
        hatch_address = 32'hFFFF_FFFF;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (big_crb !== 1'b0 || big_hi !== 48'd0 || big_rdy !== 1'b0 || big_bsy !== 1'b0 ||
            big_wds !== 16'd0 || big_ovf !== 1'b0) begin
            bad++; $display("FAIL reset_big: crb %b hi %h rdy %b bsy %b wds %0d ovf %b want 0s",
                            big_crb, big_hi, big_rdy, big_bsy, big_wds, big_ovf);
        end
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk); #1;
        total++;
        if (big_crb !== 1'b1 || sml_crb !== 1'b1) begin
            bad++; $display("FAIL cpu_rst_rise: got %b/%b want 1/1", big_crb, sml_crb);
        end
        total++;
        if (big_hi !== 48'd0) begin bad++; $display("FAIL hi_before_load: got %h want 0", big_hi); end
        @(negedge clk);
        ld_valid = 1'b1;
        #1;
        total++;
        if (big_rdy !== 1'b0 || sml_rdy !== 1'b0) begin
            bad++; $display("FAIL ready_in_run: got %b/%b want 0/0", big_rdy, sml_rdy);
        end
        @(posedge clk); #1;
        ld_valid = 1'b0;
        total++;
        if (big_bsy !== 1'b0) begin bad++; $display("FAIL busy_in_run: got %b want 0", big_bsy); end
    endtask

    task automatic test_load_continuous();
        do_load('{48'h112233445566, 48'hAABBCCDDEEFF}, 1'b0);
        total++;
        if (big_wds !== 16'd2 || sml_wds !== 16'd2) begin
            bad++; $display("FAIL words_cont: got %0d/%0d want 2/2", big_wds, sml_wds);
        end
        read_check(32'd1, 48'hAABBCCDDEEFF, 48'hAABBCCDDEEFF, "cont_w1");
        read_check(32'd0, 48'h112233445566, 48'h112233445566, "cont_w0");
    endtask

    task automatic test_load_gapped();
        do_load('{48'h123456789ABC, 48'hFEDCBA987654}, 1'b1);
        total++;
        if (big_wds !== 16'd2) begin bad++; $display("FAIL words_gap: got %0d want 2", big_wds); end
        read_check(32'd0, 48'h123456789ABC, 48'h123456789ABC, "gap_w0");
        read_check(32'd1, 48'hFEDCBA987654, 48'hFEDCBA987654, "gap_w1");
    endtask

    task automatic test_zero_len();
        logic [47:0] none[$];
        do_load(none, 1'b0);
        total++;
        if (big_wds !== 16'd0) begin bad++; $display("FAIL words_zero: got %0d want 0", big_wds); end
        read_check(32'd0, 48'h123456789ABC, 48'h123456789ABC, "zero_w0");
    endtask

    task automatic test_abort();
        pulse_start(1'b0, 8'h00);
        send_bytes('{8'h00, 8'h02, 8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6,
                     8'hD1, 8'hD2, 8'hD3}, 1'b0);
        pulse_start(1'b1, 8'h77);
        total++;
        if (big_wds !== 16'd0) begin bad++; $display("FAIL words_cleared: got %0d want 0", big_wds); end
        send_bytes('{8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}, 1'b0);
        check_load_end();
        total++;
        if (big_wds !== 16'd1) begin bad++; $display("FAIL words_abort: got %0d want 1", big_wds); end
        read_check(32'd0, 48'h010203040506, 48'h010203040506, "abort_w0");
        read_check(32'd1, 48'hFEDCBA987654, 48'hFEDCBA987654, "abort_w1");
    endtask

    task automatic test_overflow();
        do_load('{48'hA00000000000, 48'hA00000000001, 48'hA00000000002,
                  48'hA00000000003, 48'hA00000000004}, 1'b0);
        total++;
        if (sml_wds !== 16'd5 || sml_ovf !== 1'b1) begin
            bad++; $display("FAIL ovf_small: words %0d ovf %b want 5 1", sml_wds, sml_ovf);
        end
        total++;
        if (big_wds !== 16'd5 || big_ovf !== 1'b0) begin
            bad++; $display("FAIL ovf_big: words %0d ovf %b want 5 0", big_wds, big_ovf);
        end
        read_check(32'd0, 48'hA00000000000, 48'hA00000000000, "ovf_w0");
        read_check(32'd3, 48'hA00000000003, 48'hA00000000003, "ovf_w3");
        read_check(32'd4, 48'hA00000000004, 48'd0,            "ovf_w4");
        read_check(32'h0000_0800, 48'd0, 48'd0,               "range");
    endtask

    task automatic test_reset_midload();
        pulse_start(1'b0, 8'h00);
        send_bytes('{8'h00, 8'h03, 8'hE1, 8'hE2}, 1'b0);
        @(negedge clk);
        #2 rst_b = 1'b0;
        #1;
        total++;
        if (big_bsy !== 1'b0 || big_rdy !== 1'b0 || big_crb !== 1'b0 || big_wds !== 16'd0 ||
            sml_ovf !== 1'b0) begin
            bad++; $display("FAIL reset_mid: bsy %b rdy %b crb %b wds %0d ovf %b want 0s",
                            big_bsy, big_rdy, big_crb, big_wds, sml_ovf);
        end
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk); #1;
        total++;
        if (big_crb !== 1'b1) begin bad++; $display("FAIL cpu_rst_after_reset: got %b want 1", big_crb); end
        read_check(32'd0, 48'hA00000000000, 48'hA00000000000, "mem_kept");
    endtask

    initial begin
        test_reset();
        test_load_continuous();
        test_load_gapped();
        test_zero_len();
        test_abort();
        test_overflow();
        test_reset_midload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
